zf_demapper: RTL and testbench

ZF_DEMAPPER -- requirements
Module: zf_demapper

---
 rtl/zf_demapper.sv | 240 ++++++++++++++++++++++++
 tb/tb_zf_demapper.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zf_demapper.sv
// Hard-decision demapper behind the ZF detector: slices 8 float lanes, buffers them, and serializes bytes.
// Define ZF_DEMAPPER_QAM16_EN for 16-QAM slicing (two bytes per vector); the default build slices QPSK.
module zf_demapper #(
    parameter int FIFO_DEPTH = 4,
    parameter int FRAME_LEN  = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    input  logic [255:0] X,
    output logic         accept_out,
    input  logic         accept_in,
    output logic         ready_out,
    output logic [7:0]   data_out,
    output logic         last_out,
    input  logic         soft_clr,
    output logic [15:0]  vec_count,
    output logic [7:0]   special_count,
    output logic [1:0]   fsm_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
`ifdef ZF_DEMAPPER_QAM16_EN
    localparam int ENTRY_W = 16;
`else
    localparam int ENTRY_W = 8;
`endif

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BYTE0 = 2'd1;
`ifdef ZF_DEMAPPER_QAM16_EN
    localparam logic [1:0] ST_BYTE1 = 2'd2;
`endif

    // Output handshake: a byte transfers on a rising edge where ready_out && accept_in;
    // while ready_out && !accept_in, data_out/last_out/ready_out hold.
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         state_q, state_d;
    logic               ready_q, ready_d;
    logic               last_q, last_d;
    logic [7:0]         data_q, data_d;
    logic [15:0]        frame_q, frame_d;
    logic [15:0]        vec_q, vec_d;
    logic [7:0]         special_q, special_d;
`ifdef ZF_DEMAPPER_QAM16_EN
    logic [7:0]         hi_q, hi_d;
    logic               last_pend_q, last_pend_d;
`endif

    logic [ENTRY_W-1:0] slice;
    logic               any_special;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               last_now;
    logic [ENTRY_W-1:0] head;

    always_comb begin
        slice       = '0;
        any_special = 1'b0;
        for (int i = 0; i < 8; i++) begin
`ifdef ZF_DEMAPPER_QAM16_EN
            slice[2*i+1] = ~X[32*i+31];
            slice[2*i]   = (X[32*i+30 -: 31] < 31'h40000000);
`else
            slice[i] = ~X[32*i+31];
`endif
            if (X[32*i+30 -: 8] == 8'hFF) begin
                any_special = 1'b1;
            end
        end
    end

    assign accept_out = (count_q < CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];
    assign last_now   = (frame_q == 16'(FRAME_LEN - 1));
    assign push       = enable && accept_out;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        state_d   = state_q;
        ready_d   = ready_q;
        last_d    = last_q;
        data_d    = data_q;
        frame_d   = frame_q;
        vec_d     = vec_q;
        special_d = special_q;
`ifdef ZF_DEMAPPER_QAM16_EN
        hi_d        = hi_q;
        last_pend_d = last_pend_q;
`endif
        pop = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop = 1'b1;
                end
            end
            ST_BYTE0: begin
                if (ready_q && accept_in) begin
`ifdef ZF_DEMAPPER_QAM16_EN
                    state_d = ST_BYTE1;
                    data_d  = hi_q;
                    last_d  = last_pend_q;
`else
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        ready_d = 1'b0;
                        last_d  = 1'b0;
                    end
`endif
                end
            end
`ifdef ZF_DEMAPPER_QAM16_EN
            ST_BYTE1: begin
                if (ready_q && accept_in) begin
                    if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        ready_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase

        // Frame position advances per vector as it leaves the FIFO, so last tags the right byte.
        if (pop) begin
            state_d  = ST_BYTE0;
            ready_d  = 1'b1;
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            frame_d  = last_now ? 16'd0 : frame_q + 16'd1;
`ifdef ZF_DEMAPPER_QAM16_EN
            data_d      = head[7:0];
            hi_d        = head[15:8];
            last_pend_d = last_now;
            last_d      = 1'b0;
`else
            data_d = head;
            last_d = last_now;
`endif
        end

        if (push) begin
            mem_d[wr_ptr_q] = slice;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            vec_d           = vec_q + 16'd1;
            if (any_special && (special_q != 8'hFF)) begin
                special_d = special_q + 8'd1;
            end
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (soft_clr) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            count_d   = '0;
            state_d   = ST_IDLE;
            ready_d   = 1'b0;
            last_d    = 1'b0;
            data_d    = 8'd0;
            frame_d   = 16'd0;
            vec_d     = 16'd0;
            special_d = 8'd0;
`ifdef ZF_DEMAPPER_QAM16_EN
            hi_d        = 8'd0;
            last_pend_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            last_q    <= 1'b0;
            data_q    <= 8'd0;
            frame_q   <= 16'd0;
            vec_q     <= 16'd0;
            special_q <= 8'd0;
`ifdef ZF_DEMAPPER_QAM16_EN
            hi_q        <= 8'd0;
            last_pend_q <= 1'b0;
`endif
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            state_q   <= state_d;
            ready_q   <= ready_d;
            last_q    <= last_d;
            data_q    <= data_d;
            frame_q   <= frame_d;
            vec_q     <= vec_d;
            special_q <= special_d;
`ifdef ZF_DEMAPPER_QAM16_EN
            hi_q        <= hi_d;
            last_pend_q <= last_pend_d;
`endif
        end
    end

    assign ready_out     = ready_q;
    assign data_out      = data_q;
    assign last_out      = last_q;
    assign vec_count     = vec_q;
    assign special_count = special_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_zf_demapper.sv
// Scoreboarded bench for zf_demapper (default QPSK build, FRAME_LEN=3, FIFO_DEPTH=4).
module tb_zf_demapper;

    localparam int TB_FRAME = 3;

    logic         clk;
    logic         reset_n;
    logic         enable;
    logic [255:0] X;
    logic         accept_out;
    logic         accept_in;
    logic         ready_out;
    logic [7:0]   data_out;
    logic         last_out;
    logic         soft_clr;
    logic [15:0]  vec_count;
    logic [7:0]   special_count;
    logic [1:0]   fsm_state;

    zf_demapper #(.FIFO_DEPTH(4), .FRAME_LEN(TB_FRAME)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .X(X),
        .accept_out(accept_out), .accept_in(accept_in), .ready_out(ready_out),
        .data_out(data_out), .last_out(last_out), .soft_clr(soft_clr),
        .vec_count(vec_count), .special_count(special_count), .fsm_state(fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];
    int frame_m = 0;
    int vec_m = 0;
    int spec_m = 0;
    int last_seen = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [255:0] pat(input logic [7:0] p);
        logic [255:0] r;
        for (int i = 0; i < 8; i++) begin
            r[32*i +: 32] = p[i] ? 32'h3F800000 : 32'hBF800000;
        end
        return r;
    endfunction

    task automatic clear_model();
        exp_q.delete();
        frame_m = 0;
        vec_m = 0;
        spec_m = 0;
    endtask

    // Driver: called at a negedge; holds X until captured, pushes the expected byte at capture.
    task automatic send_vec(input logic [255:0] v, input logic [7:0] exp_byte, input logic special);
        int waited = 0;
        logic lst;
        X = v;
        enable = 1'b1;
        while (!accept_out && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!accept_out) begin
            chk("send_timeout", 32'd1, 32'd0);
        end else begin
            frame_m++;
            lst = (frame_m == TB_FRAME);
            if (lst) frame_m = 0;
            exp_q.push_back({lst, exp_byte});
            vec_m++;
            if (special && spec_m < 255) spec_m++;
            @(posedge clk);
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic pulse_soft_clr();
        @(negedge clk);
        accept_in = 1'b0;
        soft_clr = 1'b1;
        clear_model();
        @(negedge clk);
        soft_clr = 1'b0;
    endtask

    // Monitor / scoreboard: samples just after the negedge, when inputs are settled.
    logic       hold_v = 1'b0;
    logic [8:0] hold_val;
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && ready_out) begin
                chk("hold_stable", {23'd0, last_out, data_out}, {23'd0, hold_val});
            end
            if (ready_out && accept_in) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {23'd0, last_out, data_out}, 32'h1FF);
                    chk("unexpected_byte_seen", 32'd1, 32'd0);
                end else begin
                    chk("byte", {23'd0, last_out, data_out}, {23'd0, exp_q.pop_front()});
                end
                if (last_out) last_seen++;
            end
            hold_v = ready_out && !accept_in;
            hold_val = {last_out, data_out};
        end
    end

    localparam logic [255:0] V031 = {32'hFFC00000, 32'h7F800000, 32'hC0400000, 32'h40400000,
                                     32'h80000000, 32'h00000000, 32'hBF800000, 32'h3F800000};

    initial begin
        logic [255:0] inf_vec;
        int last_base;
        reset_n = 1'b0; enable = 1'b0; X = '0; accept_in = 1'b0; soft_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", ready_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_last", last_out, 0);
        chk("rst_vec", vec_count, 0);
        chk("rst_special", special_count, 0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_accept", accept_out, 1);
        chk("rst_state", fsm_state, 0);

        // Mixed-sign vector with signed zeros, Inf and NaN
        accept_in = 1'b1;
        send_vec(V031, 8'b0101_0101, 1'b1);
        chk("lat_ready_lo", ready_out, 0);
        chk("vec_cnt_1", vec_count, 1);
        chk("spec_cnt_1", special_count, 1);
        @(negedge clk);
        chk("lat_ready_hi", ready_out, 1);
        chk("lat_data", data_out, 8'h55);
        wait_drain(20);

        send_vec(pat(8'hFF), 8'hFF, 1'b0);
        send_vec(pat(8'h00), 8'h00, 1'b0);
        send_vec(pat(8'hA5), 8'hA5, 1'b0);
        send_vec({32'h00000000, 32'h80000000, 32'h00000000, 32'h80000000,
                  32'h80000000, 32'h80000000, 32'h00000000, 32'h00000000}, 8'b1010_0011, 1'b0);
        wait_drain(20);
        chk("vec_cnt_5", vec_count, vec_m);
        chk("spec_cnt_5", special_count, spec_m);

        // soft_clr with buffered data discards everything
        accept_in = 1'b0;
        send_vec(pat(8'h11), 8'h11, 1'b0);
        send_vec(pat(8'h22), 8'h22, 1'b0);
        send_vec(pat(8'h33), 8'h33, 1'b0);
        pulse_soft_clr();
        chk("sclr_ready", ready_out, 0);
        chk("sclr_vec", vec_count, 0);
        chk("sclr_special", special_count, 0);
        chk("sclr_accept", accept_out, 1);
        accept_in = 1'b1;
        repeat (6) @(negedge clk);
        chk("sclr_quiet", ready_out, 0);

        // Frame marking: lasts on vectors 3 and 6
        last_base = last_seen;
        for (int i = 0; i < 7; i++) send_vec(pat(8'(8'h11 * (i + 1))), 8'(8'h11 * (i + 1)), 1'b0);
        wait_drain(30);
        chk("frame_lasts", last_seen - last_base, 2);

        // Backpressure: fill output register plus FIFO, one more held by upstream
        pulse_soft_clr();
        fork
            begin
                for (int i = 0; i < 6; i++) send_vec(pat(8'(8'h01 << i)), 8'(8'h01 << i), 1'b0);
            end
            begin
                repeat (12) @(negedge clk);
                chk("bp_accept_lo", accept_out, 0);
                chk("bp_vec", vec_count, 5);
                chk("bp_ready", ready_out, 1);
                chk("bp_head", data_out, 8'h01);
                accept_in = 1'b1;
            end
        join
        wait_drain(30);

        // Special counter saturation
        pulse_soft_clr();
        accept_in = 1'b1;
        inf_vec = pat(8'hFF);
        inf_vec[31:0] = 32'h7F800000;
        for (int i = 0; i < 300; i++) send_vec(inf_vec, 8'hFF, 1'b1);
        chk("sat_vec", vec_count, 300);
        chk("sat_special", special_count, 255);
        wait_drain(30);

        // Asynchronous reset while bytes are buffered
        accept_in = 1'b0;
        for (int i = 0; i < 4; i++) send_vec(pat(8'(8'h0F + i)), 8'(8'h0F + i), 1'b0);
        chk("arst_pre_ready", ready_out, 1);
        #2;
        reset_n = 1'b0;
        clear_model();
        #1;
        chk("arst_ready", ready_out, 0);
        chk("arst_data", data_out, 0);
        chk("arst_vec", vec_count, 0);
        chk("arst_state", fsm_state, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("arst_accept", accept_out, 1);
        accept_in = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_quiet", ready_out, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
